// File: rtl/frame_tx_queue.sv
// frame_tx_queue: packet FIFO feeding a frame sender, holding each head packet through its frame plus a guard interval
module frame_tx_queue #(
    parameter int WIDTH    = 16,
    parameter int LOGSIZE  = 1,
    parameter int LOGDEPTH = 2,
    parameter int GUARD    = 16
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                wr_valid,
    input  logic [WIDTH-1:0]    wr_data,
    output logic                wr_ready,
    output logic                tx_start,
    input  logic [LOGSIZE-1:0]  tx_index,
    output logic [WIDTH-1:0]    tx_data,
    input  logic                tx_ready_at_next,
    output logic [LOGDEPTH:0]   pkt_count,
    output logic                busy
);
    localparam int AW = LOGDEPTH + LOGSIZE;
    localparam int GW = $clog2(GUARD + 1);
    localparam logic [AW:0] CAP = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] PKT = (AW+1)'(1 << LOGSIZE);

    typedef enum logic [1:0] {IDLE, START, SEND, DRAIN} state_t;

    state_t            state, nxt;
    logic [WIDTH-1:0]  mem [2**AW];
    logic [AW-1:0]     wp;
    logic [LOGDEPTH-1:0] rp;
    logic [AW:0]       used;
    logic [GW-1:0]     guard;
    logic              acc, done, rel;

    assign wr_ready = used < CAP;
    assign acc      = wr_valid && wr_ready;
    assign done     = acc && &wp[LOGSIZE-1:0];
    assign rel      = state == DRAIN && guard == '0;
    assign tx_data  = mem[{rp, tx_index}];

    always_ff @(posedge clock)
        if (acc) mem[wp] <= wr_data;

    always_ff @(posedge clock)
        if (!reset_n) state <= IDLE;
        else          state <= nxt;

    always_comb begin
        nxt = state == IDLE  ? (pkt_count != '0 && tx_ready_at_next ? START : IDLE)
            : state == START ? SEND
            : state == SEND  ? (tx_ready_at_next ? DRAIN : SEND)
            : (guard == '0 ? IDLE : DRAIN);
    end

    always_comb begin
        tx_start = state == START;
        busy     = state != IDLE;
    end

    // rp only moves on release, so the head packet is frozen from START to the end of DRAIN
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wp        <= '0;
            rp        <= '0;
            used      <= '0;
            pkt_count <= '0;
            guard     <= '0;
        end else begin
            wp        <= wp + AW'(acc);
            rp        <= rp + LOGDEPTH'(rel);
            used      <= used + (AW+1)'(acc) - (rel ? PKT : '0);
            pkt_count <= pkt_count + (LOGDEPTH+1)'(done) - (LOGDEPTH+1)'(rel);
            guard     <= state == SEND && tx_ready_at_next ? GW'(GUARD - 1)
                       : state == DRAIN && guard != '0 ? guard - 1'b1 : guard;
        end
    end
endmodule

// File: tb/tb_frame_tx_queue.sv
// tb_frame_tx_queue: directed checks of queueing, frame start, guard release and reset abort
module tb_frame_tx_queue;
    logic        clock = 0;
    logic        reset_n = 0;
    logic        wr_valid = 0;
    logic [15:0] wr_data = '0;
    logic        wr_ready;
    logic        tx_start;
    logic [0:0]  tx_index = '0;
    logic [15:0] tx_data;
    logic        tx_ready_at_next = 0;
    logic [2:0]  pkt_count;
    logic        busy;
    int          n_chk = 0;
    int          n_err = 0;

    frame_tx_queue dut (
        .clock(clock), .reset_n(reset_n), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_ready(wr_ready), .tx_start(tx_start), .tx_index(tx_index), .tx_data(tx_data),
        .tx_ready_at_next(tx_ready_at_next), .pkt_count(pkt_count), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset_n = 0;
        repeat (2) @(negedge clock);
        reset_n = 1;
    endtask

    task automatic wr(input logic [15:0] d);
        wr_valid = 1;
        wr_data  = d;
        @(negedge clock);
        wr_valid = 0;
    endtask

    task automatic peek(input string tag, input logic i, input logic [15:0] exp);
        tx_index = i;
        #1 check(tag, tx_data, exp);
    endtask

    task automatic start_frame(input logic [15:0] h0, input logic [15:0] h1);
        tx_ready_at_next = 1;
        @(negedge clock);
        check("start_pulse", tx_start, 1);
        check("start_busy", busy, 1);
        tx_ready_at_next = 0;
        @(negedge clock);
        check("start_one_cycle", tx_start, 0);
        peek("head_w0", 0, h0);
        peek("head_w1", 1, h1);
    endtask

    task automatic finish_frame(input int pc, input logic rdy, input logic w, input logic [15:0] d);
        tx_ready_at_next = 1;
        @(negedge clock);
        tx_ready_at_next = 0;
        check("drain_busy", busy, 1);
        repeat (15) @(negedge clock);
        check("pre_release_pc", pkt_count, pc);
        check("pre_release_rdy", wr_ready, rdy);
        check("pre_release_busy", busy, 1);
        if (w) begin
            wr_valid = 1;
            wr_data  = d;
        end
        @(negedge clock);
        wr_valid = 0;
        check("release_idle", busy, 0);
    endtask

    initial begin
        int starts;
        do_reset();
        check("rst_busy", busy, 0);
        check("rst_pc", pkt_count, 0);
        check("rst_rdy", wr_ready, 1);
        check("rst_start", tx_start, 0);

        tx_ready_at_next = 1;
        wr(16'h1234);
        check("t1_pc_w1", pkt_count, 0);
        wr(16'hABCD);
        check("t1_pc_w2", pkt_count, 1);
        check("t1_no_start_yet", tx_start, 0);
        @(negedge clock);
        check("t1_start", tx_start, 1);
        tx_ready_at_next = 0;
        @(negedge clock);
        check("t1_start_off", tx_start, 0);
        peek("t1_w0", 0, 16'h1234);
        peek("t1_w1", 1, 16'hABCD);
        finish_frame(1, 1, 0, 16'h0);
        check("t1_released", pkt_count, 0);

        do_reset();
        tx_ready_at_next = 1;
        wr(16'h5555);
        starts = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (tx_start) starts++;
        end
        check("t2_no_start", starts, 0);
        check("t2_pc", pkt_count, 0);
        check("t2_busy", busy, 0);

        do_reset();
        tx_ready_at_next = 0;
        for (int i = 0; i < 8; i++) wr(16'h1000 + 16'(i));
        check("t3_full_rdy", wr_ready, 0);
        check("t3_full_pc", pkt_count, 4);
        wr(16'hDEAD);
        check("t3_ninth_pc", pkt_count, 4);
        check("t3_ninth_rdy", wr_ready, 0);
        peek("t3_head_intact", 0, 16'h1000);

        start_frame(16'h1000, 16'h1001);
        finish_frame(4, 0, 0, 16'h0);
        check("t4_rel_pc", pkt_count, 3);
        check("t4_rel_rdy", wr_ready, 1);
        wr(16'hBEEF);
        wr(16'hBEE0);
        check("t4_refill_pc", pkt_count, 4);
        check("t4_refill_rdy", wr_ready, 0);
        peek("t4_new_head", 0, 16'h1002);

        start_frame(16'h1002, 16'h1003);
        finish_frame(4, 0, 0, 16'h0);
        check("t5_pc", pkt_count, 3);
        start_frame(16'h1004, 16'h1005);
        for (int i = 0; i < 2; i++) begin
            wr_valid = 1;
            wr_data  = i == 0 ? 16'h7777 : 16'h8888;
            peek("t5_track", 1'(i), i == 0 ? 16'h1004 : 16'h1005);
            @(negedge clock);
        end
        wr_valid = 0;
        peek("t5_after_w0", 0, 16'h1004);
        peek("t5_after_w1", 1, 16'h1005);
        check("t5_filled_pc", pkt_count, 4);
        finish_frame(4, 0, 0, 16'h0);
        check("t5_rel_pc", pkt_count, 3);
        peek("t5_next_head", 0, 16'h1006);

        start_frame(16'h1006, 16'h1007);
        wr(16'h9999);
        check("t6_half_pc", pkt_count, 3);
        finish_frame(3, 1, 1, 16'hAAAA);
        check("t6_same_cycle_pc", pkt_count, 3);
        check("t6_same_cycle_rdy", wr_ready, 1);
        wr(16'hBBBB);
        check("t6_used_rdy1", wr_ready, 1);
        check("t6_used_pc1", pkt_count, 3);
        wr(16'hCCCC);
        check("t6_used_rdy2", wr_ready, 0);
        check("t6_used_pc2", pkt_count, 4);
        start_frame(16'hBEEF, 16'hBEE0);
        finish_frame(4, 0, 0, 16'h0);
        peek("t6_visible_w0", 0, 16'h7777);
        peek("t6_visible_w1", 1, 16'h8888);

        do_reset();
        for (int i = 0; i < 6; i++) wr(16'h2000 + 16'(i));
        check("t7_pc", pkt_count, 3);
        start_frame(16'h2000, 16'h2001);
        tx_ready_at_next = 1;
        @(negedge clock);
        repeat (3) @(negedge clock);
        check("t7_in_drain", busy, 1);
        reset_n = 0;
        @(negedge clock);
        reset_n = 1;
        check("t7_busy", busy, 0);
        check("t7_pc0", pkt_count, 0);
        check("t7_rdy", wr_ready, 1);
        check("t7_no_start", tx_start, 0);
        @(negedge clock);
        check("t7_no_start2", tx_start, 0);
        check("t7_idle2", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
